// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending controller: coin and product
// codes, default prices, datapath widths and the controller state encoding.
package coffee_pkg;

    localparam int unsigned COIN_W     = 3;   // width of the coin code
    localparam int unsigned SEL_W      = 2;   // width of the product code
    localparam int unsigned CREDIT_W   = 5;   // credit / change width, 25-cent units
    localparam int unsigned COIN_VAL_W = 4;   // width of a decoded coin value

    // Coin codes as presented by the coin acceptor
    localparam logic [COIN_W-1:0] COIN_NONE   = 3'd0;
    localparam logic [COIN_W-1:0] COIN_25     = 3'd1;
    localparam logic [COIN_W-1:0] COIN_50     = 3'd2;
    localparam logic [COIN_W-1:0] COIN_100    = 3'd3;
    localparam logic [COIN_W-1:0] COIN_200    = 3'd4;
    localparam logic [COIN_W-1:0] COIN_BAD_A  = 3'd5;
    localparam logic [COIN_W-1:0] COIN_BAD_B  = 3'd6;
    localparam logic [COIN_W-1:0] COIN_CANCEL = 3'd7;

    // Product codes from the keypad
    localparam logic [SEL_W-1:0] PROD_NONE      = 2'd0;
    localparam logic [SEL_W-1:0] PROD_CAFE      = 2'd1;
    localparam logic [SEL_W-1:0] PROD_CAPUCCINO = 2'd2;
    localparam logic [SEL_W-1:0] PROD_CHOCOLATE = 2'd3;

    // Default prices and credit ceiling, 25-cent units
    localparam int unsigned DEF_PRICE_CAFE      = 4;
    localparam int unsigned DEF_PRICE_CAPUCCINO = 6;
    localparam int unsigned DEF_PRICE_CHOCOLATE = 8;
    localparam int unsigned DEF_CREDIT_MAX      = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_e;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin-code decoder.
// Ports:
//   dinheiro_i - raw 3-bit coin code (0 = no coin)
//   valid_c    - code is a real coin (1..4)
//   value_c    - credit value of the coin in 25-cent units (0 if not valid)
//   cancel_c   - code 7, customer pressed cancel
//   invalid_c  - codes 5/6, unrecognised coin to be rejected
module coin_decoder
    import coffee_pkg::*;
(
    input  logic [COIN_W-1:0]     dinheiro_i,
    output logic                  valid_c,
    output logic [COIN_VAL_W-1:0] value_c,
    output logic                  cancel_c,
    output logic                  invalid_c
);

    // Map each coin code onto its value / class
    always_comb begin
        valid_c   = 1'b0;
        value_c   = '0;
        cancel_c  = 1'b0;
        invalid_c = 1'b0;
        case (dinheiro_i)
            COIN_25: begin
                valid_c = 1'b1;
                value_c = COIN_VAL_W'(1);
            end
            COIN_50: begin
                valid_c = 1'b1;
                value_c = COIN_VAL_W'(2);
            end
            COIN_100: begin
                valid_c = 1'b1;
                value_c = COIN_VAL_W'(4);
            end
            COIN_200: begin
                valid_c = 1'b1;
                value_c = COIN_VAL_W'(8);
            end
            COIN_BAD_A, COIN_BAD_B: invalid_c = 1'b1;
            COIN_CANCEL:            cancel_c  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/coffee_machine_ctrl.sv
// Coffee vending controller: accumulates coin credit, dispenses the selected
// product when the credit covers its price, then returns the change.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   dinheiro          - coin code, one event per nonzero cycle (7 = cancel)
//   selec_produto     - product request (0 = none)
//   credito           - current credit, 25-cent units
//   produto, entrega  - product code and one-cycle dispense strobe
//   troco, troco_valid- change amount and its one-cycle strobe
//   moeda_rejeitada   - one-cycle strobe for a rejected coin
//   saldo_insuf       - one-cycle strobe for a selection lacking credit
// All outputs are registered.
module coffee_machine_ctrl
    import coffee_pkg::*;
#(
    parameter int unsigned PRICE_CAFE      = DEF_PRICE_CAFE,
    parameter int unsigned PRICE_CAPUCCINO = DEF_PRICE_CAPUCCINO,
    parameter int unsigned PRICE_CHOCOLATE = DEF_PRICE_CHOCOLATE,
    parameter int unsigned CREDIT_MAX      = DEF_CREDIT_MAX
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic [COIN_W-1:0]   dinheiro,
    input  logic [SEL_W-1:0]    selec_produto,
    output logic [CREDIT_W-1:0] credito,
    output logic [SEL_W-1:0]    produto,
    output logic                entrega,
    output logic [CREDIT_W-1:0] troco,
    output logic                troco_valid,
    output logic                moeda_rejeitada,
    output logic                saldo_insuf
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_e state_q, state_d;

    logic [CREDIT_W-1:0] credito_q, credito_d;
    logic [SEL_W-1:0]    produto_q, produto_d;
    logic                entrega_q, entrega_d;
    logic [CREDIT_W-1:0] troco_q, troco_d;
    logic                troco_valid_q, troco_valid_d;
    logic                rejeitada_q, rejeitada_d;
    logic                insuf_q, insuf_d;

    logic                  coin_valid_c;
    logic [COIN_VAL_W-1:0] coin_value_c;
    logic                  coin_cancel_c;
    logic                  coin_invalid_c;

    logic                coin_event_c;
    logic                sel_event_c;
    logic [CREDIT_W-1:0] price_c;
    logic [SUM_W-1:0]    sum_c;
    logic                coin_fits_c;
    logic                afford_c;
    logic                accepting_c;

    coin_decoder u_coin_decoder (
        .dinheiro_i (dinheiro),
        .valid_c    (coin_valid_c),
        .value_c    (coin_value_c),
        .cancel_c   (coin_cancel_c),
        .invalid_c  (coin_invalid_c)
    );

    // Price of the requested product
    always_comb begin
        price_c = '0;
        case (selec_produto)
            PROD_CAFE:      price_c = CREDIT_W'(PRICE_CAFE);
            PROD_CAPUCCINO: price_c = CREDIT_W'(PRICE_CAPUCCINO);
            PROD_CHOCOLATE: price_c = CREDIT_W'(PRICE_CHOCOLATE);
            default:        price_c = '0;
        endcase
    end

    // Shared decision terms; the sum carries one extra bit so overflow is visible
    assign coin_event_c = (dinheiro != COIN_NONE);
    assign sel_event_c  = (selec_produto != PROD_NONE);
    assign sum_c        = SUM_W'(credito_q) + SUM_W'(coin_value_c);
    assign coin_fits_c  = (sum_c <= SUM_W'(CREDIT_MAX));
    assign afford_c     = (credito_q >= price_c);
    assign accepting_c  = (state_q == IDLE) || (state_q == CREDIT);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a coin event always takes precedence over a selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CREDIT: begin
                if (coin_event_c) begin
                    if (coin_valid_c && coin_fits_c) begin
                        state_d = CREDIT;
                    end else if (coin_cancel_c && (state_q == CREDIT)) begin
                        state_d = CHANGE;
                    end
                end else if (sel_event_c && afford_c) begin
                    state_d = DISPENSE;
                end
            end
            DISPENSE: state_d = CHANGE;
            CHANGE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        credito_d     = credito_q;
        produto_d     = PROD_NONE;
        entrega_d     = 1'b0;
        troco_d       = '0;
        troco_valid_d = 1'b0;
        rejeitada_d   = 1'b0;
        insuf_d       = 1'b0;

        if (accepting_c) begin
            if (coin_event_c) begin
                if (coin_valid_c) begin
                    if (coin_fits_c) begin
                        credito_d = sum_c[CREDIT_W-1:0];
                    end else begin
                        rejeitada_d = 1'b1;
                    end
                end else if (coin_invalid_c) begin
                    rejeitada_d = 1'b1;
                end else if (coin_cancel_c && (state_q == CREDIT)) begin
                    // Refund the whole credit through the change path
                    troco_d       = credito_q;
                    troco_valid_d = 1'b1;
                    credito_d     = '0;
                end
            end else if (sel_event_c) begin
                if (afford_c) begin
                    entrega_d = 1'b1;
                    produto_d = selec_produto;
                    credito_d = credito_q - price_c;
                end else begin
                    insuf_d = 1'b1;
                end
            end
        end else begin
            // Coins arriving while busy are not credited; cancel is simply ignored
            if (coin_event_c && !coin_cancel_c) begin
                rejeitada_d = 1'b1;
            end
            if (state_q == DISPENSE) begin
                troco_d       = credito_q;
                troco_valid_d = 1'b1;
                credito_d     = '0;
            end
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credito_q     <= '0;
            produto_q     <= PROD_NONE;
            entrega_q     <= 1'b0;
            troco_q       <= '0;
            troco_valid_q <= 1'b0;
            rejeitada_q   <= 1'b0;
            insuf_q       <= 1'b0;
        end else begin
            credito_q     <= credito_d;
            produto_q     <= produto_d;
            entrega_q     <= entrega_d;
            troco_q       <= troco_d;
            troco_valid_q <= troco_valid_d;
            rejeitada_q   <= rejeitada_d;
            insuf_q       <= insuf_d;
        end
    end

    assign credito         = credito_q;
    assign produto         = produto_q;
    assign entrega         = entrega_q;
    assign troco           = troco_q;
    assign troco_valid     = troco_valid_q;
    assign moeda_rejeitada = rejeitada_q;
    assign saldo_insuf     = insuf_q;

endmodule

// File: tb/tb_coffee_machine_ctrl.sv
// Scoreboard bench for coffee_machine_ctrl: expected strobe events are queued
// with the stimulus and a monitor compares them whenever a strobe appears.
module tb_coffee_machine_ctrl;

    logic       clock;
    logic       reset;
    logic [2:0] dinheiro;
    logic [1:0] selec_produto;
    logic [4:0] credito;
    logic [1:0] produto;
    logic       entrega;
    logic [4:0] troco;
    logic       troco_valid;
    logic       moeda_rejeitada;
    logic       saldo_insuf;

    typedef struct packed {
        logic       ent;
        logic       tv;
        logic       rej;
        logic       ins;
        logic [1:0] prod;
        logic [4:0] chg;
        logic [4:0] cred;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    coffee_machine_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .dinheiro        (dinheiro),
        .selec_produto   (selec_produto),
        .credito         (credito),
        .produto         (produto),
        .entrega         (entrega),
        .troco           (troco),
        .troco_valid     (troco_valid),
        .moeda_rejeitada (moeda_rejeitada),
        .saldo_insuf     (saldo_insuf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input logic ent, input logic tv, input logic rej,
                               input logic ins, input logic [1:0] prod,
                               input logic [4:0] chg, input logic [4:0] cred);
        ev_t e;
        e.ent  = ent;
        e.tv   = tv;
        e.rej  = rej;
        e.ins  = ins;
        e.prod = prod;
        e.chg  = chg;
        e.cred = cred;
        return e;
    endfunction

    // Drive one cycle of inputs starting at a falling edge
    task automatic apply(input logic [2:0] c, input logic [1:0] s);
        dinheiro      = c;
        selec_produto = s;
        @(negedge clock);
        dinheiro      = 3'd0;
        selec_produto = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset         = 1'b0;
        dinheiro      = 3'd0;
        selec_produto = 2'd0;

        fork
            // Monitor: every strobe cycle must match the next queued event
            begin
                forever begin
                    ev_t got;
                    ev_t req;
                    @(negedge clock);
                    if (reset && (entrega || troco_valid || moeda_rejeitada || saldo_insuf)) begin
                        got = mk(entrega, troco_valid, moeda_rejeitada, saldo_insuf,
                                 produto, troco, credito);
                        if (exp_q.size() == 0) begin
                            check("unexpected_strobe", 32'(got), 32'd0);
                        end else begin
                            req = exp_q.pop_front();
                            check("strobe_event", 32'(got), 32'(req));
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout, expected end of test");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({credito, produto, entrega, troco, troco_valid,
                                    moeda_rejeitada, saldo_insuf}), 32'd0);
        reset = 1'b1;
        idle(1);

        // 4 + 2 = 6, cafe costs 4 -> change 2
        apply(3'd3, 2'd0); check("credit_4", 32'(credito), 32'd4);
        apply(3'd2, 2'd0); check("credit_6", 32'(credito), 32'd6);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 5'd2));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2, 5'd0));
        apply(3'd0, 2'd1);
        idle(2);
        check("credit_after_cafe", 32'(credito), 32'd0);

        // Chocolate with 4 refused, then with 8 dispensed exactly
        apply(3'd3, 2'd0); check("credit_4b", 32'(credito), 32'd4);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 5'd4));
        apply(3'd0, 2'd3);
        check("credit_kept_4", 32'(credito), 32'd4);
        apply(3'd3, 2'd0); check("credit_8", 32'(credito), 32'd8);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd0, 5'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0));
        apply(3'd0, 2'd3);
        idle(2);

        // Ceiling: 16 accepted exactly, then overflow and invalid code rejected
        apply(3'd4, 2'd0);
        apply(3'd4, 2'd0); check("credit_16", 32'(credito), 32'd16);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 5'd16));
        apply(3'd1, 2'd0); check("credit_16_overflow", 32'(credito), 32'd16);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 5'd16));
        apply(3'd5, 2'd0); check("credit_16_invalid", 32'(credito), 32'd16);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd16, 5'd0));
        apply(3'd7, 2'd0);
        idle(1);
        check("credit_after_refund16", 32'(credito), 32'd0);

        // Cancel refunds 2
        apply(3'd2, 2'd0); check("credit_2", 32'(credito), 32'd2);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2, 5'd0));
        apply(3'd7, 2'd0);
        idle(1);

        // Coin and selection together: coin wins
        apply(3'd3, 2'd1); check("coin_wins", 32'(credito), 32'd4);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 5'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0));
        apply(3'd0, 2'd1);
        idle(2);

        // Capuccino from 8, with a coin arriving during DISPENSE
        apply(3'd4, 2'd0); check("credit_8b", 32'(credito), 32'd8);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd0, 5'd2));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd2, 5'd0));
        apply(3'd0, 2'd2);
        apply(3'd1, 2'd0);
        idle(1);
        check("busy_coin_not_credited", 32'(credito), 32'd0);

        // Cancel in IDLE ignored; selection with no credit refused
        apply(3'd7, 2'd0); check("idle_cancel", 32'(credito), 32'd0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 5'd0));
        apply(3'd0, 2'd1);

        // Overflow below the ceiling: 12 + 8 rejected, 12 + 4 accepted
        apply(3'd4, 2'd0);
        apply(3'd3, 2'd0); check("credit_12", 32'(credito), 32'd12);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 5'd12));
        apply(3'd4, 2'd0); check("credit_12_kept", 32'(credito), 32'd12);
        apply(3'd3, 2'd0); check("credit_16b", 32'(credito), 32'd16);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd16, 5'd0));
        apply(3'd7, 2'd0);
        idle(1);

        // Asynchronous reset mid-credit
        apply(3'd3, 2'd0);
        apply(3'd2, 2'd0); check("credit_6_pre_reset", 32'(credito), 32'd6);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", 32'({credito, produto, entrega, troco, troco_valid,
                                             moeda_rejeitada, saldo_insuf}), 32'd0);
        idle(2);
        reset = 1'b1;
        apply(3'd7, 2'd0); check("post_reset_idle_cancel", 32'(credito), 32'd0);
        apply(3'd1, 2'd0); check("post_reset_credit_1", 32'(credito), 32'd1);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd1, 5'd0));
        apply(3'd7, 2'd0);
        idle(3);

        check("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
